mem_wb_estagio: RTL

//  Memory-access + write-back stage of the 16-bit pipeline; producer side of the register-file write port
//  (entrada_ULA, entrada_MD, controle, BR_Hab_Escrita, BR_Sel_E_SA) consumed by the decode/register-read stage.

---
 rtl/mem_wb_pkg.sv | 6 +
 rtl/reg_scoreboard.sv | 31 +++
 rtl/mem_wb_estagio.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared widths and FSM state type for the memory/write-back stage.
package mem_wb_pkg;
    localparam int DADO_W_PAD = 16;
    localparam int REG_W_PAD  = 3;
    typedef enum logic [1:0] {OCIOSO, ESPERA_MD, ESCRITA} estado_t;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write bits and the decode hazard check.
module reg_scoreboard #(
    parameter int REG_W = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               set,
    input  logic [REG_W-1:0]   set_idx,
    input  logic               clr,
    input  logic [REG_W-1:0]   clr_idx,
    input  logic [REG_W-1:0]   sel_a,
    input  logic [REG_W-1:0]   sel_b,
    output logic [2**REG_W-1:0] pendente,
    output logic               hazard
);
    logic [2**REG_W-1:0] pend_q, pend_d;

    always_comb begin
        pend_d = pend_q;
        if (clr) pend_d[clr_idx] = 1'b0;
        if (set) pend_d[set_idx] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pend_q <= '0;
        else          pend_q <= pend_d;
    end

    assign pendente = pend_q;
    assign hazard   = pend_q[sel_a] | pend_q[sel_b];
endmodule

// File: rtl/mem_wb_estagio.sv
// mem_wb_estagio: memory-access + write-back stage; one op in flight, req/ack data memory,
// single-cycle register write and pending-write scoreboard for decode stalls.
module mem_wb_estagio
    import mem_wb_pkg::*;
#(
    parameter int DADO_W  = DADO_W_PAD,
    parameter int REG_W   = REG_W_PAD,
    parameter int TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [DADO_W-1:0]   ex_resultado,
    input  logic [DADO_W-1:0]   ex_dado_store,
    input  logic [REG_W-1:0]    ex_dest,
    input  logic                ex_escreve,
    input  logic                ex_le_mem,
    input  logic                ex_escreve_mem,
    output logic                md_req,
    output logic                md_we,
    output logic [DADO_W-1:0]   md_addr,
    output logic [DADO_W-1:0]   md_wdata,
    input  logic                md_ack,
    input  logic [DADO_W-1:0]   md_rdata,
    output logic [DADO_W-1:0]   entrada_ULA,
    output logic [DADO_W-1:0]   entrada_MD,
    output logic                controle,
    output logic                BR_Hab_Escrita,
    output logic [REG_W-1:0]    BR_Sel_E_SA,
    input  logic [REG_W-1:0]    id_sel_a,
    input  logic [REG_W-1:0]    id_sel_b,
    output logic                hazard,
    output logic [2**REG_W-1:0] pendente,
    output logic                erro_md
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    estado_t           estado_q, estado_d;
    logic [DADO_W-1:0] res_q, res_d, st_q, st_d, md_q, md_d;
    logic [REG_W-1:0]  dest_q, dest_d;
    logic              esc_q, esc_d, le_q, le_d, we_q, we_d, erro_q, erro_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_set, pend_clr;

    always_comb begin
        estado_d = estado_q;
        res_d    = res_q;
        st_d     = st_q;
        md_d     = md_q;
        dest_d   = dest_q;
        esc_d    = esc_q;
        le_d     = le_q;
        we_d     = we_q;
        erro_d   = erro_q;
        cnt_d    = cnt_q;
        pend_set = 1'b0;
        pend_clr = 1'b0;
        case (estado_q)
            OCIOSO: if (ex_valid) begin
                res_d    = ex_resultado;
                st_d     = ex_dado_store;
                dest_d   = ex_dest;
                esc_d    = ex_escreve;
                le_d     = ex_le_mem;
                we_d     = ex_escreve_mem & ~ex_le_mem;
                cnt_d    = '0;
                pend_set = ex_escreve;
                estado_d = (ex_le_mem | ex_escreve_mem) ? ESPERA_MD :
                           ex_escreve ? ESCRITA : OCIOSO;
            end
            ESPERA_MD: if (md_ack) begin
                md_d     = le_q ? md_rdata : md_q;
                estado_d = (le_q & esc_q) ? ESCRITA : OCIOSO;
                // ops leaving without a write must not leave a stale pending bit
                pend_clr = ~(le_q & esc_q);
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                erro_d   = 1'b1;
                pend_clr = 1'b1;
                estado_d = OCIOSO;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            ESCRITA: begin
                pend_clr = 1'b1;
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= OCIOSO;
            res_q    <= '0;
            st_q     <= '0;
            md_q     <= '0;
            dest_q   <= '0;
            esc_q    <= 1'b0;
            le_q     <= 1'b0;
            we_q     <= 1'b0;
            erro_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            res_q    <= res_d;
            st_q     <= st_d;
            md_q     <= md_d;
            dest_q   <= dest_d;
            esc_q    <= esc_d;
            le_q     <= le_d;
            we_q     <= we_d;
            erro_q   <= erro_d;
            cnt_q    <= cnt_d;
        end
    end

    reg_scoreboard #(.REG_W(REG_W)) u_sb (
        .clock   (clock),
        .reset_n (reset_n),
        .set     (pend_set),
        .set_idx (ex_dest),
        .clr     (pend_clr),
        .clr_idx (dest_q),
        .sel_a   (id_sel_a),
        .sel_b   (id_sel_b),
        .pendente(pendente),
        .hazard  (hazard)
    );

    assign ex_ready       = (estado_q == OCIOSO);
    assign md_req         = (estado_q == ESPERA_MD);
    assign md_we          = md_req & we_q;
    assign md_addr        = res_q;
    assign md_wdata       = st_q;
    assign entrada_ULA    = res_q;
    assign entrada_MD     = md_q;
    assign BR_Hab_Escrita = (estado_q == ESCRITA);
    assign BR_Sel_E_SA    = BR_Hab_Escrita ? dest_q : '0;
    assign controle       = BR_Hab_Escrita & le_q;
    assign erro_md        = erro_q;
endmodule
